// File: rtl/jam_seq_ctrl.sv
// jam_seq_ctrl: sequencer and result checker for the JAM job-assignment datapath.
// Buffers an N x N cost matrix from a stallable valid/ready upstream, replays it
// to JAM as one unbroken in_valid burst, collects the N-cycle assignment burst,
// checks it for being a permutation and for cost-sum consistency, and offers
// jobs, total cost and error flags on a valid/ready result port.
module jam_seq_ctrl #(
  parameter int N       = 8,
  parameter int COST_W  = 7,
  parameter int JOB_W   = 4,
  parameter int TCOST_W = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [COST_W-1:0]  s_cost,
  output logic               jam_in_valid,
  output logic [COST_W-1:0]  jam_in_cost,
  input  logic               jam_out_valid,
  input  logic [JOB_W-1:0]   jam_out_job,
  input  logic [TCOST_W-1:0] jam_out_cost,
  output logic               r_valid,
  input  logic               r_ready,
  output logic [N*JOB_W-1:0] r_jobs,
  output logic [TCOST_W-1:0] r_cost,
  output logic [3:0]         r_err,
  output logic               busy
);

  localparam int WORDS  = N * N;
  localparam int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int K_W    = (N > 1) ? $clog2(N) : 1;
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
  localparam logic [K_W-1:0]    LAST_K    = K_W'(N - 1);
  localparam logic [TMO_W-1:0]  LAST_TMO  = TMO_W'(TIMEOUT - 1);

  // r_err bit meanings
  localparam logic [3:0] ERR_TIMEOUT = 4'b0001;
  localparam logic [3:0] ERR_SHORT   = 4'b0010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_WAIT,
    S_COLLECT,
    S_HOLD
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [N-1:0]       seen_q, seen_d;
  logic               perm_err_q, perm_err_d;
  logic [TCOST_W-1:0] sum_q, sum_d;

  logic               s_ready_q, s_ready_d;
  logic               jam_in_valid_q, jam_in_valid_d;
  logic [COST_W-1:0]  jam_in_cost_q, jam_in_cost_d;
  logic               r_valid_q, r_valid_d;
  logic [N*JOB_W-1:0] r_jobs_q, r_jobs_d;
  logic [TCOST_W-1:0] r_cost_q, r_cost_d;
  logic [3:0]         r_err_q, r_err_d;

  // Matrix buffer, row-major: index = worker*N + job.
  logic [COST_W-1:0] mem_q [WORDS];

  logic accept;
  assign accept = s_valid && s_ready_q;

  // Capture-path signals describing the current burst beat.
  logic               cap_fire;
  logic               cap_job_ok;
  logic [ADDR_W-1:0]  cap_addr;
  logic [N-1:0]       cap_seen;
  logic               cap_perm;
  logic [TCOST_W-1:0] cap_sum;
  logic [N*JOB_W-1:0] cap_jobs;

  // Upstream write port into the matrix buffer.
  // NOTE: the buffer has no reset; every entry is rewritten before FEED reads it,
  // so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_cnt_q] <= s_cost;
  end

  // Per-beat view of the burst: buffer lookup, seen mask and running cost sum.
  always_comb begin
    cap_fire   = jam_out_valid && (state_q == S_WAIT || state_q == S_COLLECT);
    cap_job_ok = (int'(jam_out_job) < N);
    cap_addr   = '0;
    cap_seen   = seen_q;
    cap_perm   = perm_err_q;
    cap_sum    = sum_q;
    cap_jobs   = r_jobs_q;
    cap_jobs[int'(k_q)*JOB_W +: JOB_W] = jam_out_job;
    if (cap_job_ok) begin
      cap_addr = ADDR_W'(int'(k_q) * N + int'(jam_out_job));
      if (seen_q[jam_out_job[K_W-1:0]]) cap_perm = 1'b1;
      cap_seen[jam_out_job[K_W-1:0]] = 1'b1;
      cap_sum = sum_q + TCOST_W'(mem_q[cap_addr]);
    end else begin
      // Out-of-range job: flagged as a permutation error, contributes nothing to the sum.
      cap_perm = 1'b1;
    end
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can leave
    // a signal unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    k_d            = k_q;
    seen_d         = seen_q;
    perm_err_d     = perm_err_q;
    sum_d          = sum_q;
    s_ready_d      = s_ready_q;
    jam_in_valid_d = jam_in_valid_q;
    jam_in_cost_d  = jam_in_cost_q;
    r_valid_d      = r_valid_q;
    r_jobs_d       = r_jobs_q;
    r_cost_d       = r_cost_q;
    r_err_d        = r_err_q;

    unique case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          if (wr_cnt_q == LAST_WORD) begin
            // Full matrix held: stall upstream and start the JAM burst next cycle.
            state_d        = S_FEED;
            wr_cnt_d       = '0;
            rd_cnt_d       = '0;
            s_ready_d      = 1'b0;
            jam_in_valid_d = 1'b1;
            jam_in_cost_d  = mem_q[0];
          end else begin
            state_d  = S_LOAD;
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
          end
        end
      end

      S_FEED: begin
        if (rd_cnt_q == LAST_WORD) begin
          // Last word is on the bus this cycle; arm the result collection.
          state_d        = S_WAIT;
          jam_in_valid_d = 1'b0;
          jam_in_cost_d  = '0;
          tmo_cnt_d      = '0;
          k_d            = '0;
          seen_d         = '0;
          perm_err_d     = 1'b0;
          sum_d          = '0;
          r_jobs_d       = '0;
          r_cost_d       = '0;
          r_err_d        = '0;
        end else begin
          rd_cnt_d      = rd_cnt_q + ADDR_W'(1);
          jam_in_cost_d = mem_q[rd_cnt_q + ADDR_W'(1)];
        end
      end

      S_WAIT: begin
        if (!jam_out_valid) begin
          if (tmo_cnt_q == LAST_TMO) begin
            state_d   = S_HOLD;
            r_valid_d = 1'b1;
            r_err_d   = ERR_TIMEOUT;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end
      end

      S_COLLECT: begin
        if (!jam_out_valid) begin
          // Burst ended early: report it, skip the consistency checks.
          state_d   = S_HOLD;
          r_valid_d = 1'b1;
          r_err_d   = ERR_SHORT;
        end
      end

      S_HOLD: begin
        if (r_ready) begin
          state_d   = S_IDLE;
          r_valid_d = 1'b0;
          s_ready_d = 1'b1;
        end
      end

      default: begin
        state_d        = S_IDLE;
        s_ready_d      = 1'b1;
        jam_in_valid_d = 1'b0;
        r_valid_d      = 1'b0;
      end
    endcase

    // One burst beat: the first beat happens in WAIT and also latches JAM's total.
    if (cap_fire) begin
      r_jobs_d   = cap_jobs;
      seen_d     = cap_seen;
      perm_err_d = cap_perm;
      sum_d      = cap_sum;
      if (state_q == S_WAIT) r_cost_d = jam_out_cost;
      if (k_q == LAST_K) begin
        state_d   = S_HOLD;
        r_valid_d = 1'b1;
        r_err_d   = {(cap_sum != r_cost_d), cap_perm, 2'b00};
      end else begin
        state_d = S_COLLECT;
        k_d     = k_q + K_W'(1);
      end
    end
  end

  // State, counters and registered outputs.
  // NOTE: non-blocking assignments here so every flop samples the pre-edge
  // values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      tmo_cnt_q      <= '0;
      k_q            <= '0;
      seen_q         <= '0;
      perm_err_q     <= 1'b0;
      sum_q          <= '0;
      s_ready_q      <= 1'b1;
      jam_in_valid_q <= 1'b0;
      jam_in_cost_q  <= '0;
      r_valid_q      <= 1'b0;
      r_jobs_q       <= '0;
      r_cost_q       <= '0;
      r_err_q        <= '0;
    end else begin
      state_q        <= state_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      k_q            <= k_d;
      seen_q         <= seen_d;
      perm_err_q     <= perm_err_d;
      sum_q          <= sum_d;
      s_ready_q      <= s_ready_d;
      jam_in_valid_q <= jam_in_valid_d;
      jam_in_cost_q  <= jam_in_cost_d;
      r_valid_q      <= r_valid_d;
      r_jobs_q       <= r_jobs_d;
      r_cost_q       <= r_cost_d;
      r_err_q        <= r_err_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign jam_in_valid = jam_in_valid_q;
  assign jam_in_cost  = jam_in_cost_q;
  assign r_valid      = r_valid_q;
  assign r_jobs       = r_jobs_q;
  assign r_cost       = r_cost_q;
  assign r_err        = r_err_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_jam_seq_ctrl.sv
// tb_jam_seq_ctrl: table-driven bench for jam_seq_ctrl with a behavioural JAM
// that records the FEED burst and answers with a scripted assignment burst.
module tb_jam_seq_ctrl;

  localparam int N       = 8;
  localparam int COST_W  = 7;
  localparam int JOB_W   = 4;
  localparam int TCOST_W = 10;
  localparam int TIMEOUT = 4096;
  localparam int WORDS   = N * N;
  localparam int SNAP_W  = 1 + 4 + TCOST_W + N*JOB_W;

  typedef enum int {M_OK, M_NONE, M_SHORT, M_DUP, M_COSTP1} mode_e;

  typedef struct {
    int                 mat;        // 0: diagonal zeros, 1: anti-diagonal
    mode_e              mode;       // JAM model behaviour
    bit                 stall;      // random upstream gaps
    int                 extra;      // out_valid cycles beyond N
    bit                 early;      // r_ready already high entering HOLD
    int                 hold_wait;  // cycles r_ready held low in HOLD
    logic [N*JOB_W-1:0] exp_jobs;
    logic [TCOST_W-1:0] exp_cost;
    logic [3:0]         exp_err;
  } vec_t;

  logic               clk;
  logic               rst_n;
  logic               s_valid;
  logic               s_ready;
  logic [COST_W-1:0]  s_cost;
  logic               jam_in_valid;
  logic [COST_W-1:0]  jam_in_cost;
  logic               jam_out_valid;
  logic [JOB_W-1:0]   jam_out_job;
  logic [TCOST_W-1:0] jam_out_cost;
  logic               r_valid;
  logic               r_ready;
  logic [N*JOB_W-1:0] r_jobs;
  logic [TCOST_W-1:0] r_cost;
  logic [3:0]         r_err;
  logic               busy;

  int n_vec  = 0;
  int n_fail = 0;

  logic [COST_W-1:0] rx [WORDS];
  vec_t vecs [7];
  vec_t post_rst;

  jam_seq_ctrl #(
    .N(N), .COST_W(COST_W), .JOB_W(JOB_W), .TCOST_W(TCOST_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_cost       (s_cost),
    .jam_in_valid (jam_in_valid),
    .jam_in_cost  (jam_in_cost),
    .jam_out_valid(jam_out_valid),
    .jam_out_job  (jam_out_job),
    .jam_out_cost (jam_out_cost),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .r_jobs       (r_jobs),
    .r_cost       (r_cost),
    .r_err        (r_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [COST_W-1:0] mat_word(input int sel, input int idx);
    int i = idx / N;
    int j = idx % N;
    if (sel == 0) return (i == j) ? COST_W'(0) : COST_W'(100);
    return (j == N-1-i) ? COST_W'(i) : COST_W'(120);
  endfunction

  function automatic int model_job(input int sel, input mode_e mode, input int k);
    if (mode == M_DUP && k == 1) return 0;
    return (sel == 0) ? k : N-1-k;
  endfunction

  // Upstream: one word per accepted handshake, optional random idle cycles.
  task automatic send_matrix(input int sel, input bit stall);
    int i = 0;
    int guard = 0;
    while (i < WORDS && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (stall && ($urandom_range(0, 1) == 1)) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_cost  = mat_word(sel, i);
        if (s_ready) i++;
      end
    end
    check("upstream_words", i, WORDS);
  endtask

  // JAM input side: record the FEED burst and check it is contiguous and in order.
  task automatic feed_capture(input int sel);
    int   len = 0;
    int   guard = 0;
    int   bad = 0;
    logic lat_ok;
    @(negedge clk);
    s_valid = 1'b0;
    s_cost  = '0;
    lat_ok  = jam_in_valid;
    while (!jam_in_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    while (jam_in_valid && len < 2*WORDS) begin
      if (len < WORDS) begin
        rx[len] = jam_in_cost;
        if (jam_in_cost !== mat_word(sel, len)) bad++;
      end
      len++;
      @(negedge clk);
    end
    check("feed_latency", lat_ok, 1);
    check("feed_len", len, WORDS);
    check("feed_data_errs", bad, 0);
    check("feed_idle_cost", jam_in_cost, 0);
  endtask

  // JAM output side: scripted assignment burst built from the recorded matrix.
  task automatic jam_respond(input vec_t v);
    int cost = 0;
    int nb;
    if (v.early) r_ready = 1'b1;
    if (v.mode != M_NONE) begin
      for (int k = 0; k < N; k++) cost += int'(rx[k*N + model_job(v.mat, v.mode, k)]);
      if (v.mode == M_COSTP1) cost += 1;
      nb = (v.mode == M_SHORT) ? 5 : N;
      repeat (3) @(negedge clk);
      for (int k = 0; k < nb; k++) begin
        jam_out_valid = 1'b1;
        jam_out_job   = JOB_W'(model_job(v.mat, v.mode, k));
        jam_out_cost  = TCOST_W'(cost);
        @(negedge clk);
      end
      if (nb == N) check("rvalid_latency", r_valid, 1);
      for (int e = 0; e < v.extra; e++) begin
        jam_out_valid = 1'b1;
        jam_out_job   = '1;
        @(negedge clk);
      end
      jam_out_valid = 1'b0;
      jam_out_job   = '0;
      jam_out_cost  = '0;
    end
  endtask

  // One complete problem: load, feed, respond, check result, handshake.
  task automatic run_vec(input vec_t v);
    int                cnt = 0;
    int                diff = 0;
    logic [SNAP_W-1:0] snap;
    send_matrix(v.mat, v.stall);
    feed_capture(v.mat);
    jam_respond(v);
    while (!r_valid && cnt < TIMEOUT + 200) begin
      @(negedge clk);
      cnt++;
    end
    check("result_seen", r_valid, 1);
    if (v.mode == M_NONE) check("timeout_latency", cnt, TIMEOUT);
    check("r_jobs", r_jobs, v.exp_jobs);
    check("r_cost", r_cost, v.exp_cost);
    check("r_err", r_err, v.exp_err);
    check("hold_s_ready_busy", {s_ready, busy}, 2'b01);
    snap = {r_valid, r_err, r_cost, r_jobs};
    for (int c = 0; c < v.hold_wait; c++) begin
      @(negedge clk);
      if ({r_valid, r_err, r_cost, r_jobs} !== snap || s_ready !== 1'b0) diff++;
    end
    if (v.hold_wait > 0) check("hold_stable_diffs", diff, 0);
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    check("after_handshake", {r_valid, s_ready, busy}, 3'b010);
  endtask

  initial begin
    int cnt;
    int guard;

    vecs[0] = '{mat:0, mode:M_OK,     stall:0, extra:0, early:0, hold_wait:0,
                exp_jobs:32'h76543210, exp_cost:10'd0,   exp_err:4'b0000};
    vecs[1] = '{mat:0, mode:M_OK,     stall:1, extra:2, early:0, hold_wait:0,
                exp_jobs:32'h76543210, exp_cost:10'd0,   exp_err:4'b0000};
    vecs[2] = '{mat:0, mode:M_SHORT,  stall:0, extra:0, early:0, hold_wait:0,
                exp_jobs:32'h00043210, exp_cost:10'd0,   exp_err:4'b0010};
    vecs[3] = '{mat:0, mode:M_DUP,    stall:0, extra:0, early:0, hold_wait:0,
                exp_jobs:32'h76543200, exp_cost:10'd100, exp_err:4'b0100};
    vecs[4] = '{mat:0, mode:M_COSTP1, stall:0, extra:0, early:1, hold_wait:0,
                exp_jobs:32'h76543210, exp_cost:10'd1,   exp_err:4'b1000};
    vecs[5] = '{mat:0, mode:M_NONE,   stall:0, extra:0, early:0, hold_wait:0,
                exp_jobs:32'h00000000, exp_cost:10'd0,   exp_err:4'b0001};
    vecs[6] = '{mat:1, mode:M_OK,     stall:1, extra:0, early:0, hold_wait:20,
                exp_jobs:32'h01234567, exp_cost:10'd28,  exp_err:4'b0000};

    rst_n         = 1'b0;
    s_valid       = 1'b0;
    s_cost        = '0;
    jam_out_valid = 1'b0;
    jam_out_job   = '0;
    jam_out_cost  = '0;
    r_ready       = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_ctrl", {s_ready, jam_in_valid, r_valid, busy}, 4'b1000);
    check("reset_data", {jam_in_cost, r_jobs, r_cost, r_err}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ctrl", {s_ready, jam_in_valid, r_valid, busy}, 4'b1000);

    for (int v = 0; v < 7; v++) begin
      run_vec(vecs[v]);
    end

    // Reset pulsed in the middle of FEED, then a fresh matrix.
    send_matrix(0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    s_cost  = '0;
    cnt     = 0;
    guard   = 0;
    while (!(jam_in_valid && cnt == 30) && guard < 200) begin
      if (jam_in_valid) cnt++;
      @(negedge clk);
      guard++;
    end
    check("midfeed_word30", jam_in_cost, mat_word(0, 30));
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {s_ready, jam_in_valid, r_valid, busy}, 4'b1000);
    check("midrst_data", {jam_in_cost, r_jobs, r_cost, r_err}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    post_rst = vecs[6];
    post_rst.hold_wait = 0;
    post_rst.stall     = 1'b0;
    run_vec(post_rst);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
